// File: rtl/armv8_imm_pkg.sv
// Shared encodings for the immediate extender and the constant-load sequencer.
// The extender control codes and the sequencer state are kept here so both ends agree.
package armv8_imm_pkg;

    localparam logic [2:0] EXT_LDST   = 3'b000;
    localparam logic [2:0] EXT_ADDSUB = 3'b001;
    localparam logic [2:0] EXT_CBZ    = 3'b010;
    localparam logic [2:0] EXT_B      = 3'b011;
    localparam logic [2:0] EXT_MOV0   = 3'b100;
    localparam logic [2:0] EXT_MOV1   = 3'b101;
    localparam logic [2:0] EXT_MOV2   = 3'b110;
    localparam logic [2:0] EXT_MOV3   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FIN   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/hw_pick.sv
// Lowest-set-bit priority encoder over the pending-halfword mask.
// one_hot_remaining flags that exactly one halfword is still pending.
module hw_pick (
    input  logic [3:0] vec,
    output logic [1:0] idx,
    output logic       one_hot_remaining
);

    always_comb begin
        idx = 2'd0;
        if (vec[0])      idx = 2'd0;
        else if (vec[1]) idx = 2'd1;
        else if (vec[2]) idx = 2'd2;
        else if (vec[3]) idx = 2'd3;
        one_hot_remaining = (vec != 4'd0) && ((vec & (vec - 4'd1)) == 4'd0);
    end

endmodule

// File: rtl/const_load_seq.sv
// Expands an LDI rd, #imm64 request into one MOVZ plus zero or more MOVK micro-ops,
// one halfword per op in ascending order, over a valid/ready issue port.
module const_load_seq
    import armv8_imm_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1,
    parameter int REG_W     = 5
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_const,
    input  logic [REG_W-1:0] req_rd,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [25:0]      op_imm26,
    output logic [2:0]       op_ctrl,
    output logic             op_keep,
    output logic [REG_W-1:0] op_rd,
    output logic             op_last,
    output logic             done
);

    seq_state_e       state_q, state_d;
    logic [3:0]       pend_q, pend_d;
    logic             first_q, first_d;
    logic [63:0]      const_q, const_d;
    logic [REG_W-1:0] rd_q, rd_d;
    logic             live_q;

    logic [1:0]  pick_idx;
    logic        pick_last;
    logic [3:0]  new_pend;
    logic [15:0] cur_hw;
    logic        issue;

    hw_pick u_hw_pick (
        .vec               (pend_q),
        .idx               (pick_idx),
        .one_hot_remaining (pick_last)
    );

    assign cur_hw = const_q[{pick_idx, 4'b0000} +: 16];
    assign issue  = (state_q == ISSUE);

    // Outputs decode registered state only; op_ready/req_valid never reach them.
    assign req_ready = live_q && (state_q == IDLE);
    assign done      = (state_q == FIN);
    assign op_valid  = issue;
    assign op_imm26  = issue ? {3'b000, pick_idx, cur_hw, 5'b00000} : 26'd0;
    assign op_ctrl   = issue ? (EXT_MOV0 | {1'b0, pick_idx}) : 3'b000;
    assign op_keep   = issue && !first_q;
    assign op_last   = issue && pick_last;
    assign op_rd     = issue ? rd_q : '0;

    always_comb begin
        new_pend = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            new_pend[k] = SKIP_ZERO ? (|req_const[16*k +: 16]) : 1'b1;
        end
        // An all-zero constant still needs its single MOVZ.
        if (new_pend == 4'b0000) new_pend = 4'b0001;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default so no latch is inferred.
        state_d = state_q;
        pend_d  = pend_q;
        first_d = first_q;
        const_d = const_q;
        rd_d    = rd_q;
        if (flush) begin
            state_d = IDLE;
            pend_d  = 4'b0000;
            first_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid && live_q) begin
                        const_d = req_const;
                        rd_d    = req_rd;
                        pend_d  = new_pend;
                        first_d = 1'b1;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        pend_d  = pend_q & ~(4'b0001 << pick_idx);
                        first_d = 1'b0;
                        if (pick_last) state_d = FIN;
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: the latched constant and rd are reset too, so nothing stale can leak after reset.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            pend_q  <= 4'b0000;
            first_q <= 1'b0;
            const_q <= 64'd0;
            rd_q    <= '0;
            live_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            state_q <= state_d;
            pend_q  <= pend_d;
            first_q <= first_d;
            const_q <= const_d;
            rd_q    <= rd_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_const_load_seq.sv
// Self-checking bench for const_load_seq: directed scenarios plus randomized constants
// compared cycle by cycle against a halfword-list model of the expected micro-op stream.
module tb_const_load_seq;

    logic        CLK = 1'b0;
    logic        resetl = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        op_ready = 1'b0;
    logic [63:0] req_const = 64'd0;
    logic [4:0]  req_rd = 5'd0;
    bit          dut_sel = 1'b0;   // 0 = SKIP_ZERO=1 instance, 1 = SKIP_ZERO=0 instance

    logic        a_req_ready, a_op_valid, a_keep, a_last, a_done;
    logic [25:0] a_imm;
    logic [2:0]  a_ctrl;
    logic [4:0]  a_rd;
    logic        b_req_ready, b_op_valid, b_keep, b_last, b_done;
    logic [25:0] b_imm;
    logic [2:0]  b_ctrl;
    logic [4:0]  b_rd;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    const_load_seq #(.SKIP_ZERO(1'b1), .REG_W(5)) u_dut_a (
        .CLK(CLK), .resetl(resetl), .flush(flush),
        .req_valid(req_valid & ~dut_sel), .req_ready(a_req_ready),
        .req_const(req_const), .req_rd(req_rd),
        .op_valid(a_op_valid), .op_ready(op_ready & ~dut_sel),
        .op_imm26(a_imm), .op_ctrl(a_ctrl), .op_keep(a_keep),
        .op_rd(a_rd), .op_last(a_last), .done(a_done)
    );

    const_load_seq #(.SKIP_ZERO(1'b0), .REG_W(5)) u_dut_b (
        .CLK(CLK), .resetl(resetl), .flush(flush),
        .req_valid(req_valid & dut_sel), .req_ready(b_req_ready),
        .req_const(req_const), .req_rd(req_rd),
        .op_valid(b_op_valid), .op_ready(op_ready & dut_sel),
        .op_imm26(b_imm), .op_ctrl(b_ctrl), .op_keep(b_keep),
        .op_rd(b_rd), .op_last(b_last), .done(b_done)
    );

    // Observed bundle of the selected instance: {valid, done, req_ready, ctrl, imm26, keep, last, rd}
    logic [38:0] obs_a, obs_b, obs;
    assign obs_a = {a_op_valid, a_done, a_req_ready, a_ctrl, a_imm, a_keep, a_last, a_rd};
    assign obs_b = {b_op_valid, b_done, b_req_ready, b_ctrl, b_imm, b_keep, b_last, b_rd};
    assign obs   = dut_sel ? obs_b : obs_a;

    typedef struct {
        logic [1:0]  k;
        logic [15:0] hw;
        logic        keep;
        logic        last;
    } exp_op_t;

    exp_op_t exp_q[$];

    // Expected op list: the kept halfwords in ascending order, MOVZ first, MOVK after.
    function automatic void model(input logic [63:0] c, input bit skip);
        exp_op_t e;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            if (!skip || c[16*k +: 16] != 16'h0) begin
                e.k    = 2'(k);
                e.hw   = c[16*k +: 16];
                e.keep = (exp_q.size() != 0);
                e.last = 1'b0;
                exp_q.push_back(e);
            end
        end
        if (exp_q.size() == 0) begin
            e.k = 2'd0; e.hw = 16'h0; e.keep = 1'b0; e.last = 1'b0;
            exp_q.push_back(e);
        end
        exp_q[exp_q.size()-1].last = 1'b1;
    endfunction

    function automatic logic [38:0] pack_op(input exp_op_t e, input logic [4:0] rd);
        logic [25:0] imm;
        imm = 26'd0;
        imm[22:21] = e.k;
        imm[20:5]  = e.hw;
        return {1'b1, 1'b0, 1'b0, 3'(4 + e.k), imm, e.keep, e.last, rd};
    endfunction

    task automatic issue_req(input string tag, input logic [63:0] c, input logic [4:0] rd);
        checks++;
        if (obs[36] !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready: got %b want 1", tag, obs[36]);
        end
        req_const = c;
        req_rd    = rd;
        req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random stalls, 2: three stall cycles on the second op
    task automatic consume(input string tag, input logic [4:0] rd, input int mode);
        int stalls;
        for (int i = 0; i < exp_q.size(); i++) begin
            stalls = 0;
            if (mode == 1) stalls = $urandom_range(0, 2);
            else if (mode == 2 && i == 1) stalls = 3;
            for (int s = 0; s <= stalls; s++) begin
                checks++;
                if (obs !== pack_op(exp_q[i], rd)) begin
                    errors++;
                    $display("FAIL %s op%0d stall%0d: got %h want %h", tag, i, s, obs, pack_op(exp_q[i], rd));
                end
                op_ready = (s == stalls);
                @(posedge CLK);
                @(negedge CLK);
            end
        end
        op_ready = 1'b0;
        checks++;
        if (obs[38:36] !== 3'b010) begin
            errors++;
            $display("FAIL %s done_cycle {valid,done,ready}: got %b want 010", tag, obs[38:36]);
        end
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (obs[38:36] !== 3'b001) begin
            errors++;
            $display("FAIL %s after_done {valid,done,ready}: got %b want 001", tag, obs[38:36]);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({obs_a, obs_b} !== 78'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h_%h want all 0", obs_a, obs_b);
        end
        @(negedge CLK);
        resetl = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({obs_a[38:36], obs_b[38:36]} !== 6'b001001) begin
            errors++;
            $display("FAIL reset_release: got %b_%b want 001_001", obs_a[38:36], obs_b[38:36]);
        end
    endtask

    task automatic test_single();
        model(64'h0000_0000_0000_1234, 1'b1);
        issue_req("single", 64'h0000_0000_0000_1234, 5'd3);
        consume("single", 5'd3, 0);
    endtask

    task automatic test_skip();
        model(64'h1111_0000_2222_3333, 1'b1);
        issue_req("skip", 64'h1111_0000_2222_3333, 5'd7);
        consume("skip", 5'd7, 0);
    endtask

    task automatic test_zero();
        model(64'd0, 1'b1);
        issue_req("zero_skip", 64'd0, 5'd1);
        consume("zero_skip", 5'd1, 0);
        dut_sel = 1'b1;
        model(64'd0, 1'b0);
        issue_req("zero_noskip", 64'd0, 5'd2);
        consume("zero_noskip", 5'd2, 0);
        dut_sel = 1'b0;
    endtask

    task automatic test_stall();
        model(64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
        issue_req("stall", 64'hAAAA_BBBB_CCCC_DDDD, 5'd9);
        consume("stall", 5'd9, 2);
    endtask

    task automatic test_flush();
        model(64'h4444_3333_2222_1111, 1'b1);
        issue_req("flush", 64'h4444_3333_2222_1111, 5'd5);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs !== pack_op(exp_q[i], 5'd5)) begin
                errors++;
                $display("FAIL flush op%0d: got %h want %h", i, obs, pack_op(exp_q[i], 5'd5));
            end
            op_ready = 1'b1;
            flush    = (i == 1);
            @(posedge CLK);
            @(negedge CLK);
        end
        flush    = 1'b0;
        op_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (obs[38:36] !== 3'b001) begin
                errors++;
                $display("FAIL flush_idle%0d {valid,done,ready}: got %b want 001", c, obs[38:36]);
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        // flush in IDLE must block a simultaneous request
        flush     = 1'b1;
        req_valid = 1'b1;
        req_const = 64'h1;
        @(posedge CLK);
        @(negedge CLK);
        flush     = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (obs[38:36] !== 3'b001) begin
            errors++;
            $display("FAIL flush_blocks_accept {valid,done,ready}: got %b want 001", obs[38:36]);
        end
        model(64'h0000_00FF_0000_0ABC, 1'b1);
        issue_req("after_flush", 64'h0000_00FF_0000_0ABC, 5'd12);
        consume("after_flush", 5'd12, 0);
    endtask

    task automatic test_reset_mid();
        model(64'h8765_4321_0FED_CBA9, 1'b1);
        issue_req("rst_mid", 64'h8765_4321_0FED_CBA9, 5'd30);
        checks++;
        if (obs !== pack_op(exp_q[0], 5'd30)) begin
            errors++;
            $display("FAIL rst_mid op0: got %h want %h", obs, pack_op(exp_q[0], 5'd30));
        end
        op_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b1;
        req_const = 64'hFFFF_FFFF_FFFF_FFFF;
        resetl    = 1'b0;
        #1;
        checks++;
        if (obs_a !== 39'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got %h want 0", obs_a);
        end
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (obs_a !== 39'd0) begin
            errors++;
            $display("FAIL rst_mid_held: got %h want 0", obs_a);
        end
        resetl    = 1'b1;
        req_valid = 1'b0;
        op_ready  = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (obs[38:36] !== 3'b001) begin
            errors++;
            $display("FAIL rst_mid_release {valid,done,ready}: got %b want 001", obs[38:36]);
        end
        model(64'h0000_5555_0000_0000, 1'b1);
        issue_req("after_rst", 64'h0000_5555_0000_0000, 5'd4);
        consume("after_rst", 5'd4, 0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] c;
        logic [4:0]  rd;
        for (int n = 0; n < 48; n++) begin
            dut_sel = (n >= 40);
            c  = {$urandom(), $urandom()};
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 2) == 0) c[16*k +: 16] = 16'h0;
            end
            rd = 5'($urandom_range(0, 31));
            model(c, !dut_sel);
            issue_req("random", c, rd);
            consume("random", rd, 1);
        end
        dut_sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_skip();
        test_zero();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/const_load_seq.md
# const_load_seq

Multi-cycle sequencer that materialises a 64-bit constant into a register by issuing a MOVZ followed by zero or more MOVK halfword operations. Each issued op carries the 26-bit immediate field and 3-bit extender control that the immediate extender consumes: codes 100–111 mean halfword shifted by 0/16/32/48. The block sits between a pseudo-instruction front end (`LDI rd, #imm64`) and the datapath's issue port. It is a valid/ready producer of micro-ops.

## Interface
Parameters:
- `SKIP_ZERO`, default 1: when 1, all-zero halfwords after the first issue are skipped; when 0, all four halfwords are always issued.
- `REG_W`, default 5: destination register index width.

Ports:
- `CLK`  in  1  rising-edge clock; the block uses this single clock.
- `resetl`  in  1  reset, asynchronous assert, active low.
- `flush`  in  1  synchronous abort of any sequence in progress.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when both `req_valid` and `req_ready` are 1.
- `req_const`  in  64  constant to load.
- `req_rd`  in  REG_W  destination register.
- `op_valid`  out  1  micro-op present.
- `op_ready`  in  1  datapath takes the op when both `op_valid` and `op_ready` are 1.
- `op_imm26`  out  26  immediate field: [22:21]=hw index k, [20:5]=halfword, all other bits 0.
- `op_ctrl`  out  3  extender control = {1'b1, k}.
- `op_keep`  out  1  0 = MOVZ (clear the other bits), 1 = MOVK (keep the other bits).
- `op_rd`  out  REG_W  latched `req_rd`.
- `op_last`  out  1  this op is the final op of the sequence.
- `done`  out  1  one-cycle pulse after the last op is taken.

## Operation
- States: IDLE, ISSUE, FIN.
- IDLE:
  - `req_ready`=1.
  - On accept, latch `req_const` and `req_rd`.
  - Compute `pend[k]` = |halfword k (halfword k = bits [16k+15:16k]); with SKIP_ZERO=0, `pend`=4'b1111.
  - If `pend`==0, force `pend`=4'b0001.
  - Set `first`=1 and go to ISSUE.
- ISSUE:
  - `op_valid`=1.
  - k = index of the lowest set bit of `pend`.
  - Payload is formatted as described in the Interface.
  - `op_keep`=!`first`.
  - `op_last` = (`pend` has exactly one bit set).
  - On handshake: clear `pend[k]` and set `first`=0. If that bit was the last one, go to FIN.
  - While `op_ready`=0, hold all payload stable.
- FIN: `done`=1 and `req_ready`=0 for exactly one cycle, then go to IDLE.
- Halfwords are issued in ascending k order. The number of ops equals popcount(`pend`), which is 1 to 4.
- `flush` has priority over everything else:
  - It moves the block to IDLE next cycle and clears `pend` and `first`.
  - No `done` pulse is produced.
  - An op handshake in the same cycle as `flush` counts as squashed.
  - In IDLE, `flush` blocks acceptance even if `req_valid`=1.
- `resetl` low (at any time, including mid-sequence):
  - Block goes to IDLE immediately.
  - `op_valid`, `done`, `op_*` outputs and all internal registers are 0.
  - `req_ready` reads 0 while reset is asserted and 1 from the first cycle after release.

## Timing
- Request accepted at edge n → first `op_valid` in cycle n+1.
- Each handshake advances the sequence by one op, so the block sustains 1 op per cycle.
- The last handshake at edge m → `done`=1 in cycle m+1 → `req_ready`=1 in cycle m+2.
- Best-case request-to-request spacing: popcount + 2 cycles.
- All outputs come from registers (state, `pend`, `first`, latched const/rd) through a priority encoder and muxes only. There is no combinational path from `op_ready` or `req_valid` to any output.

## Structure
- Package `armv8_imm_pkg` holds:
  - Extender control localparams: EXT_LDST=000, EXT_ADDSUB=001, EXT_CBZ=010, EXT_B=011, EXT_MOV0..EXT_MOV3=100..111.
  - The state encoding: IDLE, ISSUE, FIN.
- One sub-module, `hw_pick`: a 4-bit lowest-set-bit priority encoder that outputs a 2-bit index and a `one_hot_remaining` flag.

## Test plan
- Const 0x0000_0000_0000_1234, rd=3 → exactly one op: ctrl=100, imm26[20:5]=0x1234, keep=0, last=1, rd=3. `done` pulses in the following cycle.
- Const 0x1111_0000_2222_3333, SKIP_ZERO=1, `op_ready`=1 → three consecutive ops:
  - ctrl=100, imm 0x3333, keep=0.
  - ctrl=101, imm 0x2222, keep=1.
  - ctrl=111, imm 0x1111, keep=1, last=1.
- Const 0 → one op: ctrl=100, imm26=0, keep=0, last=1. With SKIP_ZERO=0 → four ops, ctrl 100..111, all with imm 0.
- Const 0xAAAA_BBBB_CCCC_DDDD with `op_ready` held low for 3 cycles during the second op → ctrl=101 and imm 0xCCCC held stable throughout. The total op count is still 4.
- `flush` asserted on the cycle the second op of 4 is valid → IDLE next cycle, no `done`, `req_ready`=1. A new request then starts cleanly with keep=0.
- `resetl` dropped mid-sequence while `req_valid`=1 → `op_valid`/`done` read 0 in the same cycle. After release: no stale ops, and the first op of the next request has keep=0.
